// File: rtl/trace_pkg.sv
// ============================================================================
// Module  : trace_pkg
// Brief   : Shared types and the record match rule for the trace checker.
//           Build option: TRACE_CHECKER_R0_FILTER_EN (treat x0 writes as no-write)
// Revision: 1.0
// ============================================================================
`default_nettype none

package trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rd;
    logic [31:0] value;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  function automatic logic rec_match(input trace_rec_t got, input trace_rec_t exp);
    logic got_ena;
    logic exp_ena;
    got_ena = got.ena;
    exp_ena = exp.ena;
`ifdef TRACE_CHECKER_R0_FILTER_EN
    // A write to x0 is architecturally invisible, so treat it as no write.
    if (got.rd == 5'd0) got_ena = 1'b0;
    if (exp.rd == 5'd0) exp_ena = 1'b0;
`else
`endif
    return (got.pc == exp.pc) && (got_ena == exp_ena) &&
           (!got_ena || ((got.rd == exp.rd) && (got.value == exp.value)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module  : trace_fifo
// Brief   : Synchronous record FIFO with a registered head and wrap-bit pointers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  trace_rec_t wdata_i,
  input  logic       pop_i,
  output trace_rec_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  trace_rec_t  mem_q [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = push_i && (!full_o || pop_i);
  assign w_do_pop  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/trace_checker.sv
// ============================================================================
// Module  : trace_checker
// Brief   : Compares the CPU write-back trace against a golden record stream.
//           Build option: TRACE_CHECKER_R0_FILTER_EN (see trace_pkg::rec_match)
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_checker
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_have_inst,
  input  logic [31:0]      wb_pc,
  input  logic             wb_ena,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_value,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [31:0]      ref_pc,
  input  logic             ref_ena,
  input  logic [4:0]       ref_reg,
  input  logic [31:0]      ref_value,
  input  logic             ref_last,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             overflow,
  output logic [CNT_W-1:0] inst_count,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_got_value,
  output logic [31:0]      err_exp_value,
  output logic [4:0]       err_got_reg,
  output logic [4:0]       err_exp_reg
);

  state_e             state_q;
  logic               done_q;
  logic               pass_q;
  logic               fail_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   inst_count_q;
  logic [31:0]        err_pc_q;
  logic [31:0]        err_got_value_q;
  logic [31:0]        err_exp_value_q;
  logic [4:0]         err_got_reg_q;
  logic [4:0]         err_exp_reg_q;

  trace_rec_t w_wb_rec;
  trace_rec_t w_ref_rec;
  trace_rec_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_ovf;
  logic       w_match;

  assign w_wb_rec  = '{pc: wb_pc, ena: wb_ena, rd: wb_reg, value: wb_value};
  assign w_ref_rec = '{pc: ref_pc, ena: ref_ena, rd: ref_reg, value: ref_value};

  assign w_push    = (state_q == ST_RUN) && wb_have_inst;
  assign w_pop     = (state_q == ST_RUN) && !w_empty && ref_valid;
  assign w_ovf     = w_push && w_full && !w_pop;
  assign w_match   = rec_match(w_head, w_ref_rec);

  trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .wdata_i (w_wb_rec),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      overflow_q      <= 1'b0;
      inst_count_q    <= '0;
      err_pc_q        <= '0;
      err_got_value_q <= '0;
      err_exp_value_q <= '0;
      err_got_reg_q   <= '0;
      err_exp_reg_q   <= '0;
    end else if (state_q == ST_RUN) begin
      if (w_pop) begin
        if (w_match) begin
          if (inst_count_q != '1) inst_count_q <= inst_count_q + CNT_W'(1);
          if (ref_last) begin
            state_q <= ST_PASS;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end
        end else begin
          state_q         <= ST_FAIL;
          done_q          <= 1'b1;
          fail_q          <= 1'b1;
          err_pc_q        <= w_head.pc;
          err_got_value_q <= w_head.value;
          err_got_reg_q   <= w_head.rd;
          err_exp_value_q <= ref_value;
          err_exp_reg_q   <= ref_reg;
        end
      end
      if (w_ovf) begin
        state_q    <= ST_FAIL;
        done_q     <= 1'b1;
        fail_q     <= 1'b1;
        overflow_q <= 1'b1;
        // A same-cycle mismatch keeps ownership of the error details.
        if (!(w_pop && !w_match)) begin
          err_pc_q        <= wb_pc;
          err_got_value_q <= wb_value;
          err_got_reg_q   <= wb_reg;
          err_exp_value_q <= '0;
          err_exp_reg_q   <= '0;
        end
      end
    end
  end

  assign ref_ready     = w_pop;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign overflow      = overflow_q;
  assign inst_count    = inst_count_q;
  assign err_pc        = err_pc_q;
  assign err_got_value = err_got_value_q;
  assign err_exp_value = err_exp_value_q;
  assign err_got_reg   = err_got_reg_q;
  assign err_exp_reg   = err_exp_reg_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_checker.sv
// ============================================================================
// Module  : tb_trace_checker
// Brief   : Scoreboard bench for trace_checker (honours TRACE_CHECKER_R0_FILTER_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trace_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_have_inst = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        wb_ena = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_value = '0;
  logic        ref_valid = 1'b0;
  logic        ref_ready;
  logic [31:0] ref_pc = '0;
  logic        ref_ena = 1'b0;
  logic [4:0]  ref_reg = '0;
  logic [31:0] ref_value = '0;
  logic        ref_last = 1'b0;
  logic        done, pass, fail, overflow;
  logic [31:0] inst_count;
  logic [31:0] err_pc, err_got_value, err_exp_value;
  logic [4:0]  err_got_reg, err_exp_reg;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  trace_checker #(
    .FIFO_DEPTH (8),
    .CNT_W      (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_have_inst  (wb_have_inst),
    .wb_pc         (wb_pc),
    .wb_ena        (wb_ena),
    .wb_reg        (wb_reg),
    .wb_value      (wb_value),
    .ref_valid     (ref_valid),
    .ref_ready     (ref_ready),
    .ref_pc        (ref_pc),
    .ref_ena       (ref_ena),
    .ref_reg       (ref_reg),
    .ref_value     (ref_value),
    .ref_last      (ref_last),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .overflow      (overflow),
    .inst_count    (inst_count),
    .err_pc        (err_pc),
    .err_got_value (err_got_value),
    .err_exp_value (err_exp_value),
    .err_got_reg   (err_got_reg),
    .err_exp_reg   (err_exp_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    wb_have_inst = 1'b0;
    ref_valid    = 1'b0;
    ref_last     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic push_wb(input logic [31:0] pc, input logic ena, input logic [4:0] rg,
                         input logic [31:0] val);
    wb_pc = pc; wb_ena = ena; wb_reg = rg; wb_value = val;
    wb_have_inst = 1'b1;
    @(posedge clk);
    #1;
    wb_have_inst = 1'b0;
  endtask

  task automatic send_ref(input logic [31:0] pc, input logic ena, input logic [4:0] rg,
                          input logic [31:0] val, input logic last, input int exp_cnt);
    ref_pc = pc; ref_ena = ena; ref_reg = rg; ref_value = val; ref_last = last;
    ref_valid = 1'b1;
    sb.push_back(exp_cnt);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ref_ready) break;
    end
    check("ref_accept", {63'd0, ref_ready}, 64'd1);
    if (!ref_ready) void'(sb.pop_back());
    @(posedge clk);
    #1;
    ref_valid = 1'b0;
    ref_last  = 1'b0;
  endtask

  task automatic three_record_pass();
    for (int i = 0; i < 3; i++) push_wb(32'(4 * i), 1'b1, 5'(i + 1), 32'(5 + i));
    for (int i = 0; i < 3; i++) send_ref(32'(4 * i), 1'b1, 5'(i + 1), 32'(5 + i), i == 2, i + 1);
    check("pass_run_pass", {63'd0, pass}, 64'd1);
    check("pass_run_fail", {63'd0, fail}, 64'd0);
    check("pass_run_cnt", {32'd0, inst_count}, 64'd3);
  endtask

  // Scoreboard consumer: each accepted ref yields the expected count after the edge.
  initial begin
    int exp_cnt;
    forever begin
      @(negedge clk);
      if (ref_ready && !rst) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
          exp_cnt = sb.pop_front();
          @(posedge clk);
          #1;
          check("inst_count", {32'd0, inst_count}, 64'(exp_cnt));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_ready", {63'd0, ref_ready}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_pass", {63'd0, pass}, 64'd0);
    check("rst_fail", {63'd0, fail}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_cnt", {32'd0, inst_count}, 64'd0);
    check("rst_err_pc", {32'd0, err_pc}, 64'd0);

    // Straight pass
    three_record_pass();
    check("pass_done", {63'd0, done}, 64'd1);

    // Mismatch on the second record
    do_reset();
    for (int i = 0; i < 3; i++) push_wb(32'(4 * i), 1'b1, 5'(i + 1), 32'(5 + i));
    send_ref(32'h0, 1'b1, 5'd1, 32'd5, 1'b0, 1);
    send_ref(32'h4, 1'b1, 5'd2, 32'd7, 1'b0, 1);
    check("mm_fail", {63'd0, fail}, 64'd1);
    check("mm_pass", {63'd0, pass}, 64'd0);
    check("mm_ovf", {63'd0, overflow}, 64'd0);
    check("mm_err_pc", {32'd0, err_pc}, 64'h4);
    check("mm_got_val", {32'd0, err_got_value}, 64'd6);
    check("mm_exp_val", {32'd0, err_exp_value}, 64'd7);
    check("mm_got_reg", {59'd0, err_got_reg}, 64'd2);
    check("mm_exp_reg", {59'd0, err_exp_reg}, 64'd2);
    check("mm_cnt", {32'd0, inst_count}, 64'd1);
    ref_pc = 32'h8; ref_ena = 1'b1; ref_reg = 5'd3; ref_value = 32'd7; ref_last = 1'b1;
    ref_valid = 1'b1;
    @(negedge clk);
    check("mm_ready_frozen", {63'd0, ref_ready}, 64'd0);
    @(posedge clk);
    #1;
    ref_valid = 1'b0;
    push_wb(32'h30, 1'b1, 5'd9, 32'h99);
    check("mm_cnt_frozen", {32'd0, inst_count}, 64'd1);
    check("mm_err_pc_frozen", {32'd0, err_pc}, 64'h4);
    check("mm_pass_sticky", {63'd0, pass}, 64'd0);

    // Overflow: nine pushes into an eight-entry FIFO with no consumer
    do_reset();
    wb_have_inst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wb_pc = 32'h100 + 32'(4 * i); wb_ena = 1'b1; wb_reg = 5'(i + 1); wb_value = 32'hA000 + 32'(i);
      @(posedge clk);
      #1;
    end
    wb_have_inst = 1'b0;
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_fail", {63'd0, fail}, 64'd1);
    check("ovf_done", {63'd0, done}, 64'd1);
    check("ovf_err_pc", {32'd0, err_pc}, 64'h120);
    check("ovf_got_val", {32'd0, err_got_value}, 64'hA008);
    check("ovf_got_reg", {59'd0, err_got_reg}, 64'd9);
    check("ovf_exp_val", {32'd0, err_exp_value}, 64'd0);

    // Full FIFO with simultaneous push and pop is legal
    do_reset();
    for (int i = 0; i < 8; i++) push_wb(32'h200 + 32'(4 * i), 1'b1, 5'(i + 1), 32'hB0 + 32'(i));
    wb_pc = 32'h220; wb_ena = 1'b1; wb_reg = 5'd9; wb_value = 32'hB8; wb_have_inst = 1'b1;
    ref_pc = 32'h200; ref_ena = 1'b1; ref_reg = 5'd1; ref_value = 32'hB0; ref_last = 1'b0;
    ref_valid = 1'b1;
    sb.push_back(1);
    @(negedge clk);
    check("full_pop_rdy", {63'd0, ref_ready}, 64'd1);
    @(posedge clk);
    #1;
    wb_have_inst = 1'b0;
    ref_valid    = 1'b0;
    check("full_pop_ovf", {63'd0, overflow}, 64'd0);
    check("full_pop_fail", {63'd0, fail}, 64'd0);
    for (int i = 1; i < 9; i++)
      send_ref(32'h200 + 32'(4 * i), 1'b1, 5'(i + 1), 32'hB0 + 32'(i), i == 8, i + 1);
    check("full_drain_pass", {63'd0, pass}, 64'd1);
    check("full_drain_cnt", {32'd0, inst_count}, 64'd9);

    // x0 write on the CPU side against a no-write golden record
    do_reset();
    push_wb(32'h40, 1'b1, 5'd0, 32'h55);
`ifdef TRACE_CHECKER_R0_FILTER_EN
    send_ref(32'h40, 1'b0, 5'd0, 32'h0, 1'b1, 1);
    check("r0_pass", {63'd0, pass}, 64'd1);
    check("r0_fail", {63'd0, fail}, 64'd0);
`else
    send_ref(32'h40, 1'b0, 5'd0, 32'h0, 1'b1, 0);
    check("r0_pass", {63'd0, pass}, 64'd0);
    check("r0_fail", {63'd0, fail}, 64'd1);
    check("r0_got_val", {32'd0, err_got_value}, 64'h55);
`endif

    // Asynchronous reset between the second and third compare
    do_reset();
    for (int i = 0; i < 3; i++) push_wb(32'(4 * i), 1'b1, 5'(i + 1), 32'(5 + i));
    send_ref(32'h0, 1'b1, 5'd1, 32'd5, 1'b0, 1);
    send_ref(32'h4, 1'b1, 5'd2, 32'd6, 1'b0, 2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt", {32'd0, inst_count}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_pass", {63'd0, pass}, 64'd0);
    check("arst_fail", {63'd0, fail}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    ref_pc = 32'h8; ref_ena = 1'b1; ref_reg = 5'd3; ref_value = 32'd7; ref_valid = 1'b1;
    @(negedge clk);
    check("arst_empty_rdy", {63'd0, ref_ready}, 64'd0);
    @(posedge clk);
    #1;
    ref_valid = 1'b0;
    three_record_pass();

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trace_checker.md
# trace_checker

Self-checking monitor for the single-cycle CPU's write-back trace port. It consumes the per-instruction commit stream the CPU drives on its `debug_wb_*` outputs. It buffers those records in a small FIFO and compares each one, in order, against a golden record stream supplied over a valid/ready handshake. It reports PASS, FAIL or overflow, the matched-instruction count and the first mismatching record. It sits beside the CPU in the trace top level, as the reader of the CPU's trace writer.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: DUT record buffer depth; must be a power of two and at least 2.
- `CNT_W`, default 32: width of the matched-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_have_inst`  in  1  CPU committed an instruction this cycle.
- `wb_pc`  in  32  PC of the committed instruction.
- `wb_ena`  in  1  register write enable of the committed instruction.
- `wb_reg`  in  5  destination register.
- `wb_value`  in  32  write-back value.
- `ref_valid`  in  1  golden record present.
- `ref_ready`  out  1  golden record consumed this cycle.
- `ref_pc`  in  32  golden PC.
- `ref_ena`  in  1  golden write enable.
- `ref_reg`  in  5  golden destination register.
- `ref_value`  in  32  golden write-back value.
- `ref_last`  in  1  final golden record.
- `done`  out  1  checker is in PASS or FAIL.
- `pass`  out  1  all records matched through `ref_last`.
- `fail`  out  1  mismatch or overflow.
- `overflow`  out  1  FIFO overflow caused the failure.
- `inst_count`  out  CNT_W  number of matched records, saturating.
- `err_pc`, `err_got_value`, `err_exp_value`  out  32  details of the first failure.
- `err_got_reg`, `err_exp_reg`  out  5  details of the first failure.

## Operation
- States: RUN, PASS, FAIL. After reset the checker is in RUN. PASS and FAIL are sticky until `rst`.
- Push: in RUN, `wb_have_inst=1` writes {pc, ena, reg, value} into the FIFO. The CPU is never back-pressured.
- Compare fires when state is RUN, the FIFO is not empty and `ref_valid=1`. In that cycle:
  - `ref_ready=1`.
  - The FIFO head is popped.
- Match rule:
  - PC must be equal.
  - Enable must be equal.
  - When enable is 1, register and value must also be equal.
  - When enable is 0, register and value are ignored.
- On a match:
  - `inst_count` increments; it holds at all-ones instead of wrapping.
  - If `ref_last=1`, the state moves to PASS.
- On a mismatch:
  - The state moves to FAIL.
  - `err_*` capture the FIFO head (got fields) and the ref inputs (exp fields).
  - `inst_count` is unchanged.
- Overflow: the FIFO is full, a push occurs and no pop occurs in the same cycle.
  - The state moves to FAIL and `overflow=1`.
  - `err_pc` and `err_got_*` capture the incoming `wb_*` record; `err_exp_*` are 0.
- If the FIFO is full and a push and a pop happen in the same cycle, this is legal and is not an overflow.
- If a mismatch and an overflow happen in the same cycle, the mismatch takes priority for `err_*`, but `overflow` is still set.
- In PASS or FAIL:
  - `ref_ready=0`.
  - Pushes are ignored.
  - Counter and `err_*` are frozen.
- `ref_valid=1` with an empty FIFO: no action, `ref_ready=0`.

## Timing
- Reset values:
  - State RUN, FIFO empty.
  - `ref_ready`, `done`, `pass`, `fail` and `overflow` are 0.
  - `inst_count` and all `err_*` are 0.
- `ref_ready` is combinational from state, FIFO-empty and `ref_valid`. It has no dependence on `ref_*` data.
- Latency: a record pushed at edge N reaches the FIFO head after N. It is compared at edge N+1 at the earliest. `pass`/`fail` are visible after the deciding edge.
- FIFO reads are registered-head, with no read-through of the same-cycle push into an empty FIFO.
- Throughput: one compare per cycle.
- `rst` asserted mid-run clears everything immediately, independent of `clk`.

## Configuration
- `TRACE_CHECKER_R0_FILTER_EN`
  - Defined: any record with ena=1 and reg=0, on either side, is normalized to ena=0 before comparison. This hides x0 writes the CPU may or may not report.
  - Undefined: records are compared literally.

## Structure
- Package `trace_pkg`:
  - `trace_rec_t` struct {pc[31:0], ena, reg[4:0], value[31:0]}.
  - State enum {RUN, PASS, FAIL}.
  - `rec_match` function that applies the match rule and, when enabled, the R0 normalization.
- Sub-module `trace_fifo`:
  - Synchronous FIFO of `trace_rec_t`, `FIFO_DEPTH` entries.
  - Pointers with an extra wrap bit.
  - Outputs `full` and `empty`.
- Top-level `trace_checker` holds the FSM, counter and error capture.

## Test plan
- Three DUT records (pc 0x0, 0x4, 0x8, ena=1, reg 1..3, values 5/6/7) and identical refs with `ref_last` on the third → `pass=1` after the third compare, `inst_count=3`, `fail=0`.
- Second ref value 0x7 versus got 0x6 at pc 0x4 → `fail=1`, `err_pc=0x4`, `err_got_value=6`, `err_exp_value=7`, `inst_count=1`. Later records are ignored.
- `ref_valid=0` while 9 consecutive pushes occur with DEPTH 8 → `overflow=1`, `fail=1`, `err_pc` equals the 9th `wb_pc`.
- FIFO full with a push and a pop in the same cycle → no overflow; occupancy stays 8.
- DUT record ena=1, reg=0, value 0x55 against ref ena=0 → PASS with the filter macro defined, FAIL without it.
- Assert `rst` between the second and third compare → all outputs return to 0 at once; a fresh three-record run then passes.
